dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_bank.sv | 28 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// wait-counter width, latency bound and the legal byte-write masks.
package dmem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int CNT_W   = 3;
  localparam int LAT_MAX = 8;

  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam logic [3:0] WEN_B0   = 4'b0001;
  localparam logic [3:0] WEN_B1   = 4'b0010;
  localparam logic [3:0] WEN_B2   = 4'b0100;
  localparam logic [3:0] WEN_B3   = 4'b1000;
  localparam logic [3:0] WEN_H0   = 4'b0011;
  localparam logic [3:0] WEN_H1   = 4'b1100;
  localparam logic [3:0] WEN_W    = 4'b1111;

  // Byte, aligned halfword and full word stores are the only masks the CPU emits.
  function automatic logic wen_legal(input logic [3:0] wen);
    return wen inside {WEN_READ, WEN_B0, WEN_B1, WEN_B2, WEN_B3,
                       WEN_H0, WEN_H1, WEN_W};
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU data-SRAM port: request fields from the CPU, registered read word back.
interface dmem_if;

  // A request is valid when data_sram_en=1; the responder takes it only while
  // idle. While stallreq_mem is high the master holds all request fields stable.
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/dmem_bank.sv
// Word-addressed RAM built from four byte lanes, each with its own write
// enable; the read port is combinational.
module dmem_bank #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[g]) begin
        lane_mem[waddr] <= wdata[8*g +: 8];
      end
    end

    assign rdata[8*g +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM with configurable read latency and
// pipeline stall request. Define DMEM_ERR_CHECK_EN for range/mask error checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_if.slave            bus,
  output logic             stallreq_mem,
  output logic             mem_err,
  output state_e           dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic             MULTI    = (LATENCY > 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  bad_q, bad_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] bank_raddr;
  logic [31:0]           bank_rdata;
  logic [3:0]            bank_we;
  logic                  accept;
  logic                  is_read;
  logic                  req_bad;
  logic                  unused_addr_bits;

  assign req_idx          = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{bus.data_sram_addr[31:DEPTH_LOG2+2], bus.data_sram_addr[1:0]};
  assign accept           = (state_q == IDLE) && bus.data_sram_en;
  assign is_read          = (bus.data_sram_wen == WEN_READ);

`ifdef DMEM_ERR_CHECK_EN
  logic err_q, err_d;
  logic addr_oor;

  assign addr_oor = (bus.data_sram_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign req_bad  = addr_oor || !wen_legal(bus.data_sram_wen);

  always_comb begin
    err_d = err_q;
    if (accept && req_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign req_bad = 1'b0;
  assign mem_err = 1'b0;
`endif

  // During WAIT the bank must be addressed by the latched index: the CPU bus is don't-care.
  assign bank_raddr = (state_q == WAIT) ? idx_q : req_idx;

  dmem_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (req_idx),
    .wdata (bus.data_sram_wdata),
    .raddr (bank_raddr),
    .rdata (bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    bank_we = 4'b0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_read) begin
            if (!req_bad) begin
              bank_we = bus.data_sram_wen;
            end
          end else if (!MULTI) begin
            rdata_d = req_bad ? 32'd0 : bank_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            idx_d   = req_idx;
            bad_d   = req_bad;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bad_q ? 32'd0 : bank_rdata;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
    end
  end

  // Low in the last WAIT cycle so EX advances and MEM meets the data next cycle.
  assign stallreq_mem = (accept && is_read && MULTI) ||
                        ((state_q == WAIT) && (cnt_q != '0));

  assign bus.data_sram_rdata = rdata_q;
  assign dbg_state           = state_q;
  assign dbg_cnt             = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 3 and 4) driven by a
// directed vector table, hand sequences and randomized traffic vs. a model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic rst;

  logic        en_r    [3];
  logic [3:0]  wen_r   [3];
  logic [31:0] addr_r  [3];
  logic [31:0] wdata_r [3];

  logic [31:0]      rdata_o [3];
  logic [2:0]       stall_o;
  logic [2:0]       err_o;
  state_e           st_o    [3];
  logic [CNT_W-1:0] cnt_o   [3];

  dmem_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int G_LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int G_DL  = (g == 2) ? 4 : 12;

    assign bus[g].data_sram_en    = en_r[g];
    assign bus[g].data_sram_wen   = wen_r[g];
    assign bus[g].data_sram_addr  = addr_r[g];
    assign bus[g].data_sram_wdata = wdata_r[g];
    assign rdata_o[g]             = bus[g].data_sram_rdata;

    dmem_responder #(
      .DEPTH_LOG2(G_DL),
      .LATENCY   (G_LAT)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus[g]),
      .stallreq_mem (stall_o[g]),
      .mem_err      (err_o[g]),
      .dbg_state    (st_o[g]),
      .dbg_cnt      (cnt_o[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem_m      [3][4096];
  logic [31:0] exp_rd     [3];
  logic        exp_err    [3];
  int          busy_until [3];
  int          stall_until[3];
  logic [31:0] exp_q      [3][$];
  int          due_q      [3][$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  function automatic int dl_of(input int k);
    return (k == 2) ? 4 : 12;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%08h expected=%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_rd[i]      = 32'd0;
      exp_err[i]     = 1'b0;
      busy_until[i]  = cyc;
      stall_until[i] = -1;
      exp_q[i].delete();
      due_q[i].delete();
    end
  endtask

  // One bus cycle on instance k. Called at the sample point (#1 after posedge).
  task automatic step(input int k, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic stall_s, output logic [31:0] rd_s);
    logic idle, bad, exp_stall;
    int   idx, lat;
    lat = lat_of(k);
    for (int i = 0; i < 3; i++) begin
      en_r[i]  = 1'b0;
      wen_r[i] = 4'b0000;
    end
    en_r[k]    = en;
    wen_r[k]   = wen;
    addr_r[k]  = addr;
    wdata_r[k] = wdata;
    #1;
    idle      = (cyc >= busy_until[k]);
    exp_stall = (cyc <= stall_until[k]) || (idle && en && (wen == 4'b0000) && (lat > 1));
    stall_s   = stall_o[k];
    chk("stallreq_mem", {31'd0, stall_s}, {31'd0, exp_stall});
    if (idle && en) begin
      idx = int'((addr >> 2) & ((32'd1 << dl_of(k)) - 32'd1));
      bad = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
      bad = ((addr >> (dl_of(k) + 2)) != 32'd0) ||
            !(wen inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b1100, 4'b1111});
`endif
      if (bad) exp_err[k] = 1'b1;
      if (wen != 4'b0000) begin
        if (!bad) begin
          for (int b = 0; b < 4; b++) begin
            if (wen[b]) mem_m[k][idx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
        busy_until[k] = cyc + 1;
      end else begin
        exp_q[k].push_back(bad ? 32'd0 : mem_m[k][idx]);
        due_q[k].push_back(cyc + lat);
        busy_until[k]  = cyc + lat;
        stall_until[k] = cyc + lat - 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
        exp_rd[i] = exp_q[i].pop_front();
        void'(due_q[i].pop_front());
      end
    end
    rd_s = rdata_o[k];
    chk("rdata", rd_s, exp_rd[k]);
    chk("mem_err", {31'd0, err_o[k]}, {31'd0, exp_err[k]});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          inst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic        s;
    logic [31:0] rd;
    logic [3:0]  wen;
    logic [31:0] addr;
    int          words;
    logic [3:0]  legal [8];

    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en_r[i] = 1'b0; wen_r[i] = 4'b0000; addr_r[i] = 32'd0; wdata_r[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdata", rdata_o[i], 32'd0);
      chk("reset_stall", {31'd0, stall_o[i]}, 32'd0);
      chk("reset_err",   {31'd0, err_o[i]}, 32'd0);
      chk("reset_state", 32'(st_o[i]), 32'(IDLE));
      chk("reset_cnt",   32'(cnt_o[i]), 32'd0);
    end
    rst = 1'b0;
    model_reset();

    // inst 0: latency 1, byte lanes, read-after-write, back-to-back reads
    tbl.push_back('{0, 1'b1, 4'b1111, 32'h10, 32'h11223344, 1'b0, 32'h00000000});
    tbl.push_back('{0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0, 32'h00000000});
    tbl.push_back('{0, 1'b1, 4'b0000, 32'h10, 32'h0,        1'b0, 32'h11AA3344});
    tbl.push_back('{0, 1'b1, 4'b1111, 32'h40, 32'hCAFEF00D, 1'b0, 32'h11AA3344});
    tbl.push_back('{0, 1'b1, 4'b0000, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D});
    tbl.push_back('{0, 1'b1, 4'b0000, 32'h10, 32'h0,        1'b0, 32'h11AA3344});
    tbl.push_back('{0, 1'b0, 4'b0000, 32'h0,  32'h0,        1'b0, 32'h11AA3344});
    tbl.push_back('{0, 1'b1, 4'b0001, 32'h13, 32'h000000EE, 1'b0, 32'h11AA3344});
    tbl.push_back('{0, 1'b1, 4'b0000, 32'h12, 32'h0,        1'b0, 32'h11AA33EE});
    // inst 1: latency 3, request fields changed during WAIT are ignored
    tbl.push_back('{1, 1'b1, 4'b1111, 32'h20, 32'hDEADBEEF, 1'b0, 32'h00000000});
    tbl.push_back('{1, 1'b1, 4'b0000, 32'h20, 32'h0,        1'b1, 32'h00000000});
    tbl.push_back('{1, 1'b1, 4'b1111, 32'h20, 32'h00000000, 1'b1, 32'h00000000});
    tbl.push_back('{1, 1'b1, 4'b0000, 32'h24, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b1, 4'b0000, 32'h20, 32'h0,        1'b1, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b0, 4'b0000, 32'h0,  32'h0,        1'b1, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b0, 4'b0000, 32'h0,  32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b0, 4'b0000, 32'h0,  32'h0,        1'b0, 32'hDEADBEEF});

    foreach (tbl[i]) begin
      step(tbl[i].inst, tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, s, rd);
      chk($sformatf("tbl%0d_stall", i), {31'd0, s}, {31'd0, tbl[i].exp_stall});
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

`ifdef DMEM_ERR_CHECK_EN
    // illegal mask leaves RAM untouched and sets sticky error; out-of-range read returns 0
    step(0, 1'b1, 4'b0110, 32'h10, 32'hFFFFFFFF, s, rd);
    step(0, 1'b1, 4'b0000, 32'h10, 32'h0, s, rd);
    chk("err_mask_ram", rd, 32'h11AA33EE);
    chk("err_sticky", {31'd0, err_o[0]}, 32'd1);
    step(0, 1'b1, 4'b0000, 32'h10000010, 32'h0, s, rd);
    chk("err_oor_read", rd, 32'd0);
    step(0, 1'b0, 4'b0000, 32'h0, 32'h0, s, rd);
    chk("err_still_set", {31'd0, err_o[0]}, 32'd1);
`else
    // inst 2 has 16 words: byte address 0x40 aliases word 0
    step(2, 1'b1, 4'b1111, 32'h40, 32'h0BADF00D, s, rd);
    step(2, 1'b1, 4'b0000, 32'h00, 32'h0, s, rd);
    repeat (3) step(2, 1'b0, 4'b0000, 32'h0, 32'h0, s, rd);
    chk("wrap_rdata", rd, 32'h0BADF00D);
`endif

    // reset in the middle of a latency-4 read
    step(2, 1'b1, 4'b1111, 32'h08, 32'h5A5A1234, s, rd);
    step(2, 1'b1, 4'b0000, 32'h08, 32'h0, s, rd);
    repeat (3) step(2, 1'b0, 4'b0000, 32'h0, 32'h0, s, rd);
    chk("l4_read_rdata", rd, 32'h5A5A1234);
    step(2, 1'b1, 4'b0000, 32'h08, 32'h0, s, rd);
    en_r[2] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait_stall", {31'd0, stall_o[2]}, 32'd0);
    chk("rst_wait_rdata", rdata_o[2], 32'd0);
    chk("rst_wait_state", 32'(st_o[2]), 32'(IDLE));
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(2, 1'b0, 4'b0000, 32'h0, 32'h0, s, rd);
      chk("rst_no_late_update", rd, 32'd0);
    end

    // randomized traffic against the model
    for (int k = 0; k < 3; k++) begin
      words = (dl_of(k) == 12) ? 64 : 16;
      for (int w = 0; w < words; w++) begin
        step(k, 1'b1, 4'b1111, 32'(w * 4), $urandom(), s, rd);
      end
      for (int n = 0; n < 300; n++) begin
        addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) addr = addr | ($urandom() & 32'hFFFF0000);
        case ($urandom_range(0, 3))
          0, 1:    wen = 4'b0000;
          2:       wen = legal[$urandom_range(0, 7)];
          default: wen = 4'($urandom_range(1, 15));
        endcase
        step(k, ($urandom_range(0, 9) < 8), wen, addr, $urandom(), s, rd);
      end
      repeat (8) step(k, 1'b0, 4'b0000, 32'h0, 32'h0, s, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
